// File: rtl/amux_pkg.sv
// Shared types and constants for the analog mux scan sequencer.
package amux_pkg;

   localparam int unsigned N_CH = 32;
   localparam int unsigned CH_W = $clog2(N_CH);

   localparam logic [N_CH-1:0] ALL_OFF = '1;

   typedef enum logic [1:0] {
      IDLE,
      BBM,
      SETTLE,
      SAMPLE
   } state_t;

   // Active-low one-hot enable pattern selecting a single channel.
   function automatic logic [N_CH-1:0] sel_low(input logic [CH_W-1:0] ch);
      sel_low = ~(N_CH'(1) << ch);
   endfunction

endpackage

// File: rtl/amux_next_ch.sv
// Finds the next enabled channel inside a wrap-around [first_ch..last_ch] range.
module amux_next_ch
   import amux_pkg::*;
(
   input  logic [CH_W-1:0] base_ch,
   input  logic            skip_base,
   input  logic [CH_W-1:0] first_ch,
   input  logic [CH_W-1:0] last_ch,
   input  logic [N_CH-1:0] mask,
   output logic [CH_W-1:0] nxt_ch,
   output logic            exhausted
);

   localparam int unsigned DW = CH_W + 2;

   logic [DW-1:0]   span;
   logic [DW-1:0]   pos0;
   logic [DW-1:0]   pos;
   logic [CH_W-1:0] cand;

   // Positions are distances from first_ch; walking downward leaves the nearest hit.
   always_comb begin
      span      = DW'(CH_W'(last_ch - first_ch));
      pos0      = DW'(CH_W'(base_ch - first_ch)) + DW'(skip_base);
      nxt_ch    = first_ch;
      exhausted = 1'b1;
      pos       = '0;
      cand      = '0;
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
         pos  = pos0 + DW'(k);
         cand = base_ch + CH_W'(k) + CH_W'(skip_base);
         if ((pos <= span) && !mask[cand]) begin
            nxt_ch    = cand;
            exhausted = 1'b0;
         end
      end
   end

endmodule

// File: rtl/amux_scan_ctrl.sv
// Break-before-make scan sequencer for the 32:1 analog switch bank with sampler handshake.
// Optional per-channel skip mask enabled by defining AMUX_CH_MASK_EN.
module amux_scan_ctrl
   import amux_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned BBM_CYC = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cont,
   input  logic [CH_W-1:0]  first_ch,
   input  logic [CH_W-1:0]  last_ch,
   input  logic [CNT_W-1:0] settle_cyc,
`ifdef AMUX_CH_MASK_EN
   input  logic [N_CH-1:0]  ch_mask,
`endif
   input  logic             smp_ack,
   output logic             smp_req,
   output logic [CH_W-1:0]  cur_ch,
   output logic             busy,
   output logic             done,
   output logic             s_en,
   output logic             s_en_b,
   output logic [N_CH-1:0]  en_b
);

   localparam logic [CNT_W-1:0] BBM_LOAD = CNT_W'(BBM_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] settle_q;
   logic [CH_W-1:0]  first_q;
   logic [CH_W-1:0]  last_q;
   logic             cont_q;
   logic             empty_q;
   logic [N_CH-1:0]  mask_q;
   logic [N_CH-1:0]  mask_in;

   logic             idle;
   logic [CH_W-1:0]  f_first;
   logic [CH_W-1:0]  f_last;
   logic [N_CH-1:0]  f_mask;
   logic [CH_W-1:0]  f_nxt;
   logic             f_exh;
   logic [CH_W-1:0]  a_nxt;
   logic             a_exh;

`ifdef AMUX_CH_MASK_EN
   assign mask_in = ch_mask;
`else
   assign mask_in = '0;
`endif

   // The range-start finder looks at live inputs while idle and at the latched set otherwise.
   assign idle    = (state == IDLE);
   assign f_first = idle ? first_ch : first_q;
   assign f_last  = idle ? last_ch  : last_q;
   assign f_mask  = idle ? mask_in  : mask_q;

   amux_next_ch u_first (
      .base_ch   (f_first),
      .skip_base (1'b0),
      .first_ch  (f_first),
      .last_ch   (f_last),
      .mask      (f_mask),
      .nxt_ch    (f_nxt),
      .exhausted (f_exh)
   );

   amux_next_ch u_adv (
      .base_ch   (cur_ch),
      .skip_base (1'b1),
      .first_ch  (first_q),
      .last_ch   (last_q),
      .mask      (mask_q),
      .nxt_ch    (a_nxt),
      .exhausted (a_exh)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         settle_q <= '0;
         first_q  <= '0;
         last_q   <= '0;
         cont_q   <= 1'b0;
         empty_q  <= 1'b0;
         mask_q   <= '0;
         smp_req  <= 1'b0;
         cur_ch   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         s_en     <= 1'b0;
         s_en_b   <= 1'b1;
         en_b     <= ALL_OFF;
      end else begin
         done <= 1'b0;
         if (stop && (state != IDLE)) begin
            state   <= IDLE;
            smp_req <= 1'b0;
            busy    <= 1'b0;
            s_en    <= 1'b0;
            s_en_b  <= 1'b1;
            en_b    <= ALL_OFF;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !stop) begin
                     first_q  <= first_ch;
                     last_q   <= last_ch;
                     cont_q   <= cont;
                     settle_q <= settle_cyc;
                     mask_q   <= mask_in;
                     empty_q  <= f_exh;
                     cur_ch   <= f_nxt;
                     busy     <= 1'b1;
                     cnt      <= BBM_LOAD;
                     state    <= BBM;
                  end
               end
               BBM: begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (empty_q) begin
                     // Fully masked range: idle the bank until stop, or finish the pass.
                     if (cont_q) begin
                        cnt <= BBM_LOAD;
                     end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end else begin
                     en_b   <= sel_low(cur_ch);
                     s_en   <= 1'b1;
                     s_en_b <= 1'b0;
                     cnt    <= (settle_q == '0) ? '0 : settle_q - 1'b1;
                     state  <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else begin
                     smp_req <= 1'b1;
                     state   <= SAMPLE;
                  end
               end
               SAMPLE: begin
                  if (smp_ack) begin
                     smp_req <= 1'b0;
                     s_en    <= 1'b0;
                     s_en_b  <= 1'b1;
                     en_b    <= ALL_OFF;
                     if (!a_exh) begin
                        cur_ch <= a_nxt;
                        cnt    <= BBM_LOAD;
                        state  <= BBM;
                     end else if (cont_q) begin
                        cur_ch <= f_nxt;
                        cnt    <= BBM_LOAD;
                        state  <= BBM;
                     end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// Randomized directed bench for amux_scan_ctrl against a channel-list reference model.
module tb_amux_scan_ctrl;

   localparam int BBM = 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        cont;
   logic [4:0]  first_ch;
   logic [4:0]  last_ch;
   logic [7:0]  settle_cyc;
   logic [31:0] ch_mask;
   logic        smp_ack;
   logic        smp_req;
   logic [4:0]  cur_ch;
   logic        busy;
   logic        done;
   logic        s_en;
   logic        s_en_b;
   logic [31:0] en_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic inv_nb;
   logic inv_low_ok;
   logic inv_off_ok;

   amux_scan_ctrl #(
      .CNT_W   (8),
      .BBM_CYC (BBM)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .cont       (cont),
      .first_ch   (first_ch),
      .last_ch    (last_ch),
      .settle_cyc (settle_cyc),
`ifdef AMUX_CH_MASK_EN
      .ch_mask    (ch_mask),
`endif
      .smp_ack    (smp_ack),
      .smp_req    (smp_req),
      .cur_ch     (cur_ch),
      .busy       (busy),
      .done       (done),
      .s_en       (s_en),
      .s_en_b     (s_en_b),
      .en_b       (en_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control-word invariants on every cycle.
   always @(negedge clk) begin
      inv_nb     = ~s_en;
      inv_low_ok = ($countones(~en_b) <= 1);
      inv_off_ok = s_en || (en_b === 32'hFFFF_FFFF);
      chk("inv_sen_b", s_en_b, inv_nb);
      chk("inv_one_low", inv_low_ok, 1);
      chk("inv_off_open", inv_off_ok, 1);
   end

   // One scan: model builds the visit list, then latencies and selects are checked per visit.
   task automatic scan(input logic [4:0] f, input logic [4:0] l, input logic c,
                       input logic [7:0] st, input logic [31:0] m, input int nv,
                       input logic do_stop);
      int q[$];
      int span, ch, t0, r, close, g, d, n, exp_st;
      logic hold;
      logic last;
      logic [31:0] exp_en;
      span = (int'(l) - int'(f) + 32) % 32;
      for (int i = 0; i <= span; i++) begin
         ch = (int'(f) + i) % 32;
         if (!m[ch]) q.push_back(ch);
      end
      exp_st = (st == 8'd0) ? 1 : int'(st);

      first_ch = f; last_ch = l; cont = c; settle_cyc = st; ch_mask = m;
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
      first_ch = 5'($urandom); last_ch = 5'($urandom); cont = ~c;
      settle_cyc = 8'($urandom); ch_mask = $urandom;

      if (q.size() == 0) begin
         hold = 1'b1;
         if (c) begin
            repeat (20) begin
               if (en_b !== 32'hFFFF_FFFF) hold = 1'b0;
               step();
            end
            chk("empty_cont_busy", busy, 1);
            chk("empty_cont_open", hold, 1);
            stop = 1'b1; step(); stop = 1'b0;
            chk("empty_cont_stop", busy, 0);
         end else begin
            g = 0;
            while (done !== 1'b1 && g < 50) begin
               if (en_b !== 32'hFFFF_FFFF) hold = 1'b0;
               step(); g++;
            end
            chk("empty_done_lat", cyc - t0, 1 + BBM);
            chk("empty_open", hold, 1);
            chk("empty_busy", busy, 0);
         end
         return;
      end

      n = c ? nv : q.size();
      r = t0;
      for (int v = 0; v < n; v++) begin
         ch = q[v % q.size()];
         exp_en = ~(32'h1 << ch);
         g = 0;
         while (en_b === 32'hFFFF_FFFF && g < 100) begin step(); g++; end
         chk("close_lat", cyc - r, 1 + BBM);
         chk("en_b_sel", en_b, exp_en);
         chk("cur_ch", cur_ch, ch);
         close = cyc;
         g = 0;
         while (smp_req !== 1'b1 && g < 300) begin
            if ($urandom_range(0, 3) == 0) smp_ack = 1'b1;
            if ($urandom_range(0, 3) == 0) begin start = 1'b1; first_ch = 5'($urandom); end
            step();
            smp_ack = 1'b0; start = 1'b0; g++;
         end
         chk("settle_lat", cyc - close, exp_st);
         hold = 1'b1;
         d = $urandom_range(0, 3);
         repeat (d) begin
            step();
            if (smp_req !== 1'b1 || en_b !== exp_en) hold = 1'b0;
         end
         chk("req_hold", hold, 1);
         last = (v == n - 1);
         smp_ack = 1'b1;
         if (do_stop && last) stop = 1'b1;
         r = cyc;
         step();
         smp_ack = 1'b0; stop = 1'b0;
         chk("req_drop", smp_req, 0);
         chk("open_after_ack", en_b, 32'hFFFF_FFFF);
         if (last && do_stop) begin
            chk("stop_busy", busy, 0);
            chk("stop_no_done", done, 0);
            hold = 1'b1;
            repeat (BBM + 3) begin
               step();
               if (done !== 1'b0 || busy !== 1'b0 || en_b !== 32'hFFFF_FFFF) hold = 1'b0;
            end
            chk("stop_stays_idle", hold, 1);
         end else if (last) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            step();
            chk("done_one_cycle", done, 0);
         end else begin
            chk("mid_no_done", done, 0);
            chk("mid_busy", busy, 1);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
      first_ch = '0; last_ch = '0; settle_cyc = '0; ch_mask = '0; smp_ack = 1'b0;
      step(); step();
      chk("rst_en_b", en_b, 32'hFFFF_FFFF);
      chk("rst_s_en", s_en, 0);
      chk("rst_s_en_b", s_en_b, 1);
      chk("rst_smp_req", smp_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cur_ch", cur_ch, 0);
      rst_n = 1'b1;
      step();

      scan(5'd3, 5'd5, 1'b0, 8'd4, 32'h0, 0, 1'b0);
      scan(5'd30, 5'd1, 1'b0, 8'($urandom_range(0, 5)), 32'h0, 0, 1'b0);
      scan(5'd0, 5'd1, 1'b1, 8'd2, 32'h0, 5, 1'b1);
      scan(5'd9, 5'd9, 1'b1, 8'd0, 32'h0, 3, 1'b1);
      scan(5'd17, 5'd17, 1'b0, 8'd1, 32'h0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic [4:0] f;
         f = 5'($urandom);
         scan(f, f + 5'($urandom_range(0, 5)), 1'b0, 8'($urandom_range(0, 6)), 32'h0, 0, 1'b0);
      end

      // Coincident start and stop while idle: stop wins.
      first_ch = 5'd2; last_ch = 5'd4; settle_cyc = 8'd1;
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_open", en_b, 32'hFFFF_FFFF);
      repeat (BBM + 2) step();
      chk("start_stop_still_open", en_b, 32'hFFFF_FFFF);

      // Asynchronous reset while a switch is closed.
      first_ch = 5'd12; last_ch = 5'd14; cont = 1'b0; settle_cyc = 8'd10;
      start = 1'b1; step(); start = 1'b0;
      begin
         int g;
         g = 0;
         while (en_b === 32'hFFFF_FFFF && g < 50) begin step(); g++; end
      end
      step();
      chk("pre_rst_closed", s_en, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_en_b", en_b, 32'hFFFF_FFFF);
      chk("arst_s_en", s_en, 0);
      chk("arst_s_en_b", s_en_b, 1);
      chk("arst_busy", busy, 0);
      chk("arst_req", smp_req, 0);
      chk("arst_cur_ch", cur_ch, 0);
      step();
      rst_n = 1'b1;
      step();

`ifdef AMUX_CH_MASK_EN
      scan(5'd0, 5'd7, 1'b0, 8'd3, 32'h0000_005A, 0, 1'b0);
      scan(5'd0, 5'd7, 1'b0, 8'd2, 32'h0000_00FF, 0, 1'b0);
      scan(5'd4, 5'd9, 1'b0, 8'd1, 32'h0000_0010, 0, 1'b0);
      scan(5'd28, 5'd3, 1'b1, 8'd1, 32'h2000_0001, 8, 1'b1);
      scan(5'd0, 5'd3, 1'b1, 8'd1, 32'h0000_000F, 0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/amux_scan_ctrl.md
Name: amux_scan_ctrl

Overview:
- Digital sequencer directly upstream of the 32:1 analog switch bank.
- Generates the switch's s_en / s_en_b / en_b[31:0] controls, walking through a programmed channel range with break-before-make gaps.
- Handshakes each settled channel with the downstream sampler (ADC) through smp_req/smp_ack.
- All outputs are registered, so the analog controls are glitch-free.

Parameters:
- N_CH, 32, number of mux channels (width of en_b).
- CH_W, 5, channel index width, equal to clog2(N_CH).
- CNT_W, 8, width of the settle counter.
- BBM_CYC, 2, all-switches-off cycles inserted before every channel enable (minimum 1).

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a scan when idle
- stop  in  1  pulse; aborts scan, opens all switches
- cont  in  1  1 = wrap and rescan continuously; 0 = single pass
- first_ch  in  CH_W  first channel of range
- last_ch  in  CH_W  last channel of range
- settle_cyc  in  CNT_W  settle cycles after closing a switch
- smp_ack  in  1  sampler done with current channel
- smp_req  out  1  channel settled; sample now
- cur_ch  out  CH_W  channel currently selected
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at end of single pass
- s_en  out  1  global switch enable
- s_en_b  out  1  complement of s_en
- en_b  out  N_CH  per-channel enable, active-low, one-hot-low or all-ones

Behaviour:
Clock, reset and outputs:
- One clock; reset is asynchronous and active-low.
- Reset values: state IDLE, en_b all ones, s_en 0, s_en_b 1, smp_req 0, busy 0, done 0, cur_ch 0.
- Invariants at every cycle:
  - s_en_b == ~s_en.
  - s_en==0 implies en_b all ones.
  - At most one en_b bit is 0.

States:
- IDLE: switches open.
  - start=1 and stop=0: latch first_ch, last_ch, cont and settle_cyc; set cur_ch=first_ch, busy=1; go to BBM.
  - start and stop together: stop wins, remain IDLE.
- BBM: switches open; count BBM_CYC cycles, then go to SETTLE.
- SETTLE:
  - en_b[cur_ch]=0 and s_en=1, registered on entry.
  - Count settle_cyc cycles; settle_cyc=0 behaves as 1 cycle.
  - Then set smp_req=1 and go to SAMPLE.
- SAMPLE:
  - Hold the switch closed and smp_req=1 until smp_ack=1.
  - On ack: smp_req=0 next cycle, then:
    - If cur_ch==last_ch and cont=0: open the switches, pulse done for 1 cycle, busy=0, go to IDLE.
    - Otherwise: cur_ch advances to the next channel, then BBM.
- Advance: cur_ch+1 modulo N_CH, so first_ch>last_ch scans across the wrap (e.g. 30,31,0,1). cont=1 at last_ch reloads first_ch.

Latency (start pulse at cycle 0):
- First channel closes at cycle 1+BBM_CYC.
- smp_req rises settle_cyc cycles later.

Boundary rules:
- stop in any non-IDLE state: next cycle en_b all ones, s_en 0, smp_req 0, busy 0, IDLE; no done pulse.
- stop has priority over a coincident smp_ack.
- start while busy is ignored.
- smp_ack outside SAMPLE is ignored.
- first_ch==last_ch: single channel; repeats when cont=1.
- Config inputs are sampled only at start; changes mid-scan have no effect.
- Reset mid-scan opens all switches asynchronously.

Optional Feature:
Macro AMUX_CH_MASK_EN.
- Defined:
  - Adds input ch_mask [N_CH-1:0]; 1 = skip the channel, latched at start.
  - Advance selects the next unmasked channel inside the range, found combinationally in the same cycle.
  - Masked channels never see en_b low.
  - If every channel in the range is masked: no switch ever closes, and done pulses 1+BBM_CYC cycles after start (single pass). With cont=1 the block stays busy with switches open until stop.
- Undefined: port absent; every channel in range is scanned.

Decomposition:
- Package amux_pkg holds:
  - State enum: IDLE, BBM, SETTLE, SAMPLE.
  - N_CH, CH_W constants.
  - ALL_OFF constant: all-ones of width N_CH.
- One sub-module, amux_next_ch:
  - Combinational next-channel finder with wrap-around and optional mask.
  - Outputs next index and a "range exhausted" flag.

Test Plan:
1. Reset → en_b=0xFFFFFFFF, s_en=0, s_en_b=1, smp_req=0, busy=0. Assert rst_n low mid-SETTLE → same values immediately.
2. first_ch=3, last_ch=5, cont=0, settle_cyc=4, BBM_CYC=2, ack 1 cycle after each req:
   - en_b bit 3 goes low at cycle 3; smp_req rises at cycle 7.
   - Then channels 4 and 5 follow with ≥2 all-ones cycles between each.
   - done pulses once and busy falls.
3. first_ch=30, last_ch=1 → channels visited in order 30,31,0,1, then done.
4. cont=1, range 0..1 → sequence 0,1,0,1… continues. stop asserted on the same cycle as smp_ack → next cycle en_b all ones, no done, IDLE.
5. start while busy and smp_ack during SETTLE → both ignored. A checker asserts the s_en/s_en_b/en_b invariants every cycle.
6. AMUX_CH_MASK_EN, range 0..7, ch_mask=0x0000005A → channels 0,2,5,7 only. Then ch_mask=0xFF → no en_b bit ever low, done at cycle 1+BBM_CYC.
